// File: rtl/act_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : act_queue_pkg
// Description : Shared types, default widths and helpers for the activation
//               queue reader: FSM state enum, {act, idx} field-slice helpers
//               and the clogb2 sizing function.
// Revision    : 1.0 - initial release
// ============================================================================
package act_queue_pkg;

    localparam int NB_DATA_DEF = 16;
    localparam int DATA_W_DEF  = 12;
    localparam int IDX_W_DEF   = 5;
    localparam int CNT_W_DEF   = 16;

    // Depth of the output buffer in front of the MAC datapath.
    localparam int SKID_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Occupancy counter width: must represent 0 .. SKID_DEPTH inclusive.
    localparam int SKID_CNT_W = clogb2(SKID_DEPTH + 1);

    // Activation field of a queue word (upper bits above the index field).
    function automatic logic [31:0] word_act(input logic [31:0] word, input int idx_w);
        return word >> idx_w;
    endfunction

    // Index field of a queue word (low idx_w bits).
    function automatic logic [31:0] word_idx(input logic [31:0] word, input int idx_w);
        return word & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage : act_queue_pkg
`default_nettype wire

// File: rtl/act_queue_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : act_queue_reader_if
// Description : Bundles the queue-side handshake (stk_empty / rd_data /
//               read_fr_stk) and the MAC-side valid/ready output of the
//               activation queue reader.
//   master : reader view (drives read_fr_stk and out_*)
//   slave  : environment view (queue status unit, register file, MAC)
// Revision    : 1.0 - initial release
// ============================================================================
interface act_queue_reader_if
    import act_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
);
    localparam int L_DATA = DATA_W + IDX_W;

    logic              stk_empty;
    logic [L_DATA-1:0] rd_data;
    logic              read_fr_stk;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_act;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        input  stk_empty, rd_data, out_ready,
        output read_fr_stk, out_valid, out_act, out_idx
    );

    modport slave (
        output stk_empty, rd_data, out_ready,
        input  read_fr_stk, out_valid, out_act, out_idx
    );

endinterface : act_queue_reader_if
`default_nettype wire

// File: rtl/act_out_skid.sv
`default_nettype none
// ============================================================================
// Module      : act_out_skid
// Description : 2-entry in-order valid/ready buffer. Head entry is always in
//               slot 0 so the output is a plain register read; a pop shifts
//               slot 1 forward.
// Ports       :
//   clk, rst        clock, asynchronous active-high reset
//   push/push_data  write request and word (ignored unless push_ready)
//   push_ready      room for a write this cycle (full but popping counts)
//   head_valid      buffer not empty
//   head_ready      consumer accepts the head this cycle
//   head_data       head entry (held stable until accepted)
//   count           current occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module act_out_skid
    import act_queue_pkg::*;
#(
    parameter int W = DATA_W_DEF + IDX_W_DEF
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  push,
    input  wire logic [W-1:0]          push_data,
    output logic                       push_ready,
    output logic                       head_valid,
    input  wire logic                  head_ready,
    output logic [W-1:0]               head_data,
    output logic [SKID_CNT_W-1:0]      count
);

    localparam logic [SKID_CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [SKID_CNT_W-1:0] CNT_ONE  = SKID_CNT_W'(1);
    localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

    logic [W-1:0]          e0_q, e0_d;
    logic [W-1:0]          e1_q, e1_d;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop      = (cnt_q != CNT_ZERO) && head_ready;
    // A full buffer still takes a write when the head leaves the same cycle.
    assign push_ready = (cnt_q != CNT_FULL) || w_pop;
    assign w_push     = push && push_ready;

    assign head_valid = (cnt_q != CNT_ZERO);
    assign head_data  = e0_q;
    assign count      = cnt_q;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever remains.
                if (cnt_q == CNT_ONE) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            2'b10: begin
                if (cnt_q == CNT_ZERO) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
                cnt_d = cnt_q + CNT_ONE;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - CNT_ONE;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule : act_out_skid
`default_nettype wire

// File: rtl/act_queue_reader.sv
`default_nettype none
// ============================================================================
// Module      : act_queue_reader
// Description : Consumer-side controller for the PE activation queue. Pops the
//               queue while running or draining, captures {act, idx} from the
//               register file at the read pointer and hands entries to the MAC
//               datapath through a 2-entry output buffer.
// Ports       :
//   clk, rst     clock, asynchronous active-high reset
//   en           enables fetching while in RUN
//   drain_req    single-cycle request to empty the queue
//   bus          act_queue_reader_if.master: stk_empty, rd_data, read_fr_stk,
//                out_valid, out_ready, out_act, out_idx
//   busy         high in RUN or DRAIN
//   drain_done   one-cycle pulse when a drain completes
//   pop_cnt      total pops since reset (wraps)
//   skip_cnt     zero-activation words dropped (0 when zero-skip is built out)
// Build option: define ACT_QUEUE_READER_ZERO_SKIP_EN to drop popped words
//               whose act field is zero instead of forwarding them.
// Revision    : 1.0 - initial release
// ============================================================================
module act_queue_reader
    import act_queue_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               en,
    input  wire logic               drain_req,
    act_queue_reader_if.master      bus,
    output logic                    busy,
    output logic                    drain_done,
    output logic [CNT_W-1:0]        pop_cnt,
    output logic [CNT_W-1:0]        skip_cnt
);

    localparam int L_DATA = DATA_W + IDX_W;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      pop_cnt_q, pop_cnt_d;

    logic                  w_fetch;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_push_ready;
    logic                  w_head_valid;
    logic [L_DATA-1:0]     w_head_data;
    logic [SKID_CNT_W-1:0] w_buf_cnt;

    // ------------------------------------------------------------------
    // Pop decision. In RUN the en sample gates the pop in the same cycle,
    // so the cycle en drops never pops. push_ready already folds in the
    // "full but the head leaves this cycle" case.
    // ------------------------------------------------------------------
    assign w_fetch = ((state_q == RUN) && en) || (state_q == DRAIN);
    assign w_pop   = w_fetch && !bus.stk_empty && w_push_ready;
    assign bus.read_fr_stk = w_pop;

`ifdef ACT_QUEUE_READER_ZERO_SKIP_EN
    logic             w_is_zero;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    assign w_is_zero = (DATA_W'(word_act(32'(bus.rd_data), IDX_W)) == '0);
    assign w_push    = w_pop && !w_is_zero;

    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (w_pop && w_is_zero) begin
            skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt_q <= '0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign skip_cnt = skip_cnt_q;
`else
    assign w_push   = w_pop;
    assign skip_cnt = '0;
`endif

    act_out_skid #(
        .W          (L_DATA)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (bus.rd_data),
        .push_ready (w_push_ready),
        .head_valid (w_head_valid),
        .head_ready (bus.out_ready),
        .head_data  (w_head_data),
        .count      (w_buf_cnt)
    );

    assign bus.out_valid = w_head_valid;
    assign bus.out_act   = DATA_W'(word_act(32'(w_head_data), IDX_W));
    assign bus.out_idx   = IDX_W'(word_idx(32'(w_head_data), IDX_W));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Captures land in the buffer on the pop edge, so an empty
                // queue plus an empty buffer means nothing is left anywhere.
                if (bus.stk_empty && (w_buf_cnt == '0) && !w_pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                drain_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (w_pop) begin
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    assign pop_cnt = pop_cnt_q;

endmodule : act_queue_reader
`default_nettype wire

// File: tb/tb_act_queue_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_queue_reader
// Description : Self-checking bench for act_queue_reader. A queue stands in
//               for the status unit / register file; a transaction-level
//               model (mode flags, output queue, counters) predicts every
//               output each cycle. Directed scenarios are followed by a
//               randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_queue_reader;
    import act_queue_pkg::*;

    localparam int DATA_W = 12;
    localparam int IDX_W  = 5;
    localparam int L_DATA = DATA_W + IDX_W;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 16;
`ifdef ACT_QUEUE_READER_ZERO_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             drain_req;
    logic             busy;
    logic             drain_done;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] skip_cnt;

    act_queue_reader_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    act_queue_reader #(
        .NB_DATA    (DEPTH),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .drain_req  (drain_req),
        .bus        (bus),
        .busy       (busy),
        .drain_done (drain_done),
        .pop_cnt    (pop_cnt),
        .skip_cnt   (skip_cnt)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [L_DATA-1:0] stk_q[$];   // words waiting in the activation queue
    logic [L_DATA-1:0] out_q[$];   // words captured, not yet accepted by MAC
    logic [DATA_W-1:0] got_act[$]; // acts observed on accepted handshakes
    bit m_run, m_drain, m_done;
    int m_pops, m_skips;
    int done_pulses, valid_cycles, pop_cycles;
    int checks, failures;

    function automatic logic [L_DATA-1:0] mk(input int act, input int idx);
        logic [L_DATA-1:0] w;
        w = {DATA_W'(act), IDX_W'(idx)};
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] act_of(input logic [L_DATA-1:0] w);
        return w[L_DATA-1:IDX_W];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [L_DATA-1:0] w);
        return w[IDX_W-1:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk_q.delete();
        out_q.delete();
        m_run   = 1'b0;
        m_drain = 1'b0;
        m_done  = 1'b0;
        m_pops  = 0;
        m_skips = 0;
    endtask

    // One clock cycle: apply inputs on the falling edge, compare every
    // output against the model, then advance the model across the rising edge.
    task automatic step(input bit i_en, input bit i_rdy, input bit i_drain);
        logic [L_DATA-1:0] w;
        bit exp_valid, exp_hs, exp_fetch, exp_pop, stk_was_empty;
        int buf_before;
        @(negedge clk);
        en            = i_en;
        drain_req     = i_drain;
        bus.out_ready = i_rdy;
        bus.stk_empty = (stk_q.size() == 0);
        bus.rd_data   = (stk_q.size() == 0) ? L_DATA'($urandom) : stk_q[0];
        #1;
        buf_before    = out_q.size();
        stk_was_empty = (stk_q.size() == 0);
        exp_valid = (buf_before > 0);
        exp_hs    = exp_valid && i_rdy;
        exp_fetch = (m_run && i_en) || m_drain;
        exp_pop   = exp_fetch && !stk_was_empty && ((buf_before < 2) || exp_hs);

        check_eq("read_fr_stk", 32'(bus.read_fr_stk), 32'(exp_pop));
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("out_act", 32'(bus.out_act), 32'(act_of(out_q[0])));
            check_eq("out_idx", 32'(bus.out_idx), 32'(idx_of(out_q[0])));
        end
        check_eq("busy", 32'(busy), 32'(m_run || m_drain));
        check_eq("drain_done", 32'(drain_done), 32'(m_done));
        check_eq("pop_cnt", 32'(pop_cnt), m_pops & 32'hFFFF);
        check_eq("skip_cnt", 32'(skip_cnt), m_skips & 32'hFFFF);

        if (drain_done) done_pulses++;
        if (bus.out_valid) valid_cycles++;
        if (bus.read_fr_stk) pop_cycles++;
        if (bus.out_valid && bus.out_ready) got_act.push_back(bus.out_act);

        if (exp_hs) void'(out_q.pop_front());
        if (exp_pop) begin
            w = stk_q.pop_front();
            m_pops++;
            if (SKIP_EN && (act_of(w) == '0)) m_skips++;
            else out_q.push_back(w);
        end

        if (m_done) begin
            m_done = 1'b0;
        end else if (m_drain) begin
            if (stk_was_empty && (buf_before == 0)) begin
                m_drain = 1'b0;
                m_done  = 1'b1;
            end
        end else if (m_run) begin
            if (i_drain) begin
                m_run   = 1'b0;
                m_drain = 1'b1;
            end else if (!i_en) begin
                m_run = 1'b0;
            end
        end else begin
            if (i_drain) m_drain = 1'b1;
            else if (i_en) m_run = 1'b1;
        end
    endtask

    task automatic steps(input int n, input bit i_en, input bit i_rdy);
        for (int k = 0; k < n; k++) step(i_en, i_rdy, 1'b0);
    endtask

    int base_pops;
    int pops_seen;

    initial begin
        checks = 0; failures = 0;
        done_pulses = 0; valid_cycles = 0; pop_cycles = 0;
        model_reset();
        rst = 1'b1; en = 1'b0; drain_req = 1'b0;
        bus.out_ready = 1'b0; bus.stk_empty = 1'b1; bus.rd_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_act", 32'(bus.out_act), 32'd0);
        check_eq("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check_eq("rst_read_fr_stk", 32'(bus.read_fr_stk), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_drain_done", 32'(drain_done), 32'd0);
        check_eq("rst_pop_cnt", 32'(pop_cnt), 32'd0);
        check_eq("rst_skip_cnt", 32'(skip_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty queue the whole time with en=1: nothing may pop or appear.
        valid_cycles = 0; pop_cycles = 0;
        steps(10, 1'b1, 1'b1);
        check_eq("empty_pops", 32'(pop_cycles), 32'd0);
        check_eq("empty_valid", 32'(valid_cycles), 32'd0);
        check_eq("empty_pop_cnt", 32'(pop_cnt), 32'd0);

        // Three entries, MAC always ready.
        got_act.delete(); pop_cycles = 0;
        stk_q.push_back(mk(5, 1)); stk_q.push_back(mk(7, 2)); stk_q.push_back(mk(9, 3));
        steps(6, 1'b1, 1'b1);
        check_eq("t1_pops", 32'(pop_cycles), 32'd3);
        check_eq("t1_count", 32'(got_act.size()), 32'd3);
        if (got_act.size() == 3) begin
            check_eq("t1_act0", 32'(got_act[0]), 32'd5);
            check_eq("t1_act1", 32'(got_act[1]), 32'd7);
            check_eq("t1_act2", 32'(got_act[2]), 32'd9);
        end
        check_eq("t1_pop_cnt", 32'(pop_cnt), 32'd3);

        // Backpressure: four queued, MAC stalled.
        got_act.delete(); pop_cycles = 0;
        stk_q.push_back(mk(5, 1)); stk_q.push_back(mk(7, 2));
        stk_q.push_back(mk(9, 3)); stk_q.push_back(mk(11, 4));
        steps(6, 1'b1, 1'b0);
        check_eq("t2_stall_pops", 32'(pop_cycles), 32'd2);
        check_eq("t2_hold_act", 32'(bus.out_act), 32'd5);
        steps(6, 1'b1, 1'b1);
        check_eq("t2_total_pops", 32'(pop_cycles), 32'd4);
        check_eq("t2_count", 32'(got_act.size()), 32'd4);
        for (int k = 0; k < 4 && k < got_act.size(); k++)
            check_eq("t2_order", 32'(got_act[k]), 32'(5 + 2 * k));

        // Drain from RUN with two queued and en dropped.
        got_act.delete(); done_pulses = 0;
        stk_q.push_back(mk(21, 6)); stk_q.push_back(mk(22, 7));
        step(1'b0, 1'b1, 1'b1);
        steps(8, 1'b0, 1'b1);
        check_eq("t3_delivered", 32'(got_act.size()), 32'd2);
        check_eq("t3_done_pulses", 32'(done_pulses), 32'd1);
        check_eq("t3_busy_end", 32'(busy), 32'd0);

        // Reset mid-stream with one entry buffered.
        stk_q.push_back(mk(30, 8));
        steps(3, 1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0; drain_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_pop_cnt", 32'(pop_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        bus.stk_empty = 1'b1;
        rst = 1'b0;
        got_act.delete();
        stk_q.push_back(mk(13, 9));
        steps(5, 1'b1, 1'b1);
        check_eq("post_rst_count", 32'(got_act.size()), 32'd1);
        if (got_act.size() > 0) check_eq("post_rst_act", 32'(got_act[0]), 32'd13);

        // Zero-activation words.
        got_act.delete();
        base_pops = int'(pop_cnt);
        stk_q.push_back(mk(0, 1)); stk_q.push_back(mk(4, 2)); stk_q.push_back(mk(0, 3));
        steps(6, 1'b1, 1'b1);
        pops_seen = int'(pop_cnt) - base_pops;
        check_eq("zs_pop_delta", 32'(pops_seen), 32'd3);
        check_eq("zs_out_count", 32'(got_act.size()), SKIP_EN ? 32'd1 : 32'd3);
        check_eq("zs_skip_cnt", 32'(skip_cnt), SKIP_EN ? 32'd2 : 32'd0);
        if (got_act.size() > 0) check_eq("zs_first_act", 32'(got_act[0]), SKIP_EN ? 32'd4 : 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            if (stk_q.size() < DEPTH && $urandom_range(0, 2) != 0)
                stk_q.push_back(mk(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4095)),
                                   int'($urandom_range(0, 31))));
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_act_queue_reader
`default_nettype wire
